bus_dma_master: RTL
===================

# bus_dma_master

Single-channel block-copy bus master for the two-master/two-slave shared bus. It attaches to one master port (m0 or m1) of the bus and plays the initiator role against the arbiter and slave memories. On a start command it requests the bus, reads `length` words from `src_addr`, writes each to `dst_addr`, then releases the bus and pulses `done`.

## Interface
- LEN_W, 8: width of the transfer-length counter.
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle command pulse; sampled only in IDLE.
- src_addr  input  8  first source word address.
- dst_addr  input  8  first destination word address.
- length  input  LEN_W  number of words to copy; 0 is legal.
- busy  output  1  high from the cycle after an accepted start until DONE completes.
- done  output  1  one-cycle pulse at transfer end.
- m_req  output  1  bus request to the arbiter.
- m_grant  input  1  grant from the arbiter.
- m_wr  output  1  1 = write, 0 = read; valid only while granted.
- m_address  output  8  bus address.
- m_dout  output  32  write data to the bus.
- m_din  input  32  read data from the bus.

## Operation
- Bus protocol rules the block obeys:
  - Address, m_wr and m_dout are sampled by the bus in the cycle they are driven while m_grant=1.
  - Read data appears on m_din one cycle after the read address, because slave-select is registered in the bus.
  - A write completes at the clock edge ending the cycle in which it is driven.
- States: IDLE, REQ, RD, CAP, WR, DONE.
- IDLE:
  - Outputs idle.
  - On start: latch src/dst/length into sa, da, cnt.
  - length=0 goes to DONE; otherwise go to REQ.
- REQ: m_req=1; wait for m_grant=1, then go to RD.
- RD: m_req=1, m_wr=0, m_address=sa. If m_grant=1 go to CAP, else REQ.
- CAP: m_req=1, bus outputs idle. Capture m_din into data register unconditionally, then go to WR.
- WR: m_req=1, m_wr=1, m_address=da, m_dout=data.
  - If m_grant=0, go to REQ; the current word is retried from RD and sa/da/cnt are unchanged.
  - Otherwise sa+=1, da+=1, cnt-=1. If the new cnt is 0 go to DONE, else go to RD.
- DONE: m_req=0, done=1 for exactly one cycle, then IDLE.
- Idle bus outputs: m_wr=0, m_address=0, m_dout=0 whenever not in RD/WR or m_grant=0. m_wr is never 1 without grant.
- Address arithmetic is modulo 256; 8'hFF+1 wraps to 8'h00 for sa and da independently.
- start while busy is ignored; latched parameters do not change.
- Overlapping regions are not checked. Copy order is ascending, one word at a time.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE.
  - busy, done, m_req, m_wr = 0.
  - m_address=0, m_dout=0.
  - Internal registers sa, da, cnt, data = 0.
- Reset mid-transfer aborts at once. The bus is released in the same cycle; a partially copied block is left as is.
- Start accepted at edge E0; REQ and busy=1 from E0.
- With the bus arbiter, grant is registered and rises one cycle after m_req.
- Per-word cost with continuous grant: 3 cycles (RD, CAP, WR).
- Total cycles from start edge to done pulse, uncontested bus: 1 (REQ) + 1 (grant latency) + 3·length.
- length=0: done asserted the cycle after start; m_req never asserted.
- Grant loss adds the re-arbitration wait plus a repeat of RD/CAP for that word. No word is written twice with different data.

## Test plan
- Basic copy:
  - Stimulus: slave0 words 0x00–0x03 = 0xA0..0xA3; start src=0x00, dst=0x10, length=4.
  - Required: words 0x10–0x13 = 0xA0..0xA3; done exactly once; busy low afterwards; 14 cycles from start to done.
- Zero length:
  - Stimulus: start with length=0.
  - Required: done pulse the next cycle; m_req stays 0; memory unchanged.
- Wrap-around:
  - Stimulus: src=0xFE, dst=0x7F, length=3.
  - Required: reads of 0xFE, 0xFF, 0x00; writes of 0x7F, 0x80, 0x81 with matching data.
- Contention:
  - Stimulus: the other master holds the bus for 10 cycles while the DMA requests.
  - Required: no m_wr/m_address activity until grant; the copy then completes correctly.
  - Stimulus: force m_grant=0 during a WR cycle.
  - Required: that word is retried and written once with correct data.
- Busy start:
  - Stimulus: start pulse mid-transfer with different parameters.
  - Required: ignored; the original copy completes unchanged.
- Reset mid-transfer:
  - Stimulus: assert reset during word 2 of 4.
  - Required: all outputs 0 in the same cycle; words 0–1 copied, words 2–3 untouched; a new start after reset works.

Source files
------------

// File: rtl/bus_dma_master.sv
`default_nettype none
// ============================================================================
//  Module      : bus_dma_master
//  Description : Single-channel block-copy bus master. Requests the shared
//                bus, copies `length` words from src_addr to dst_addr one
//                word at a time (read, capture, write), then pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_dma_master #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       src_addr,
    input  logic [7:0]       dst_addr,
    input  logic [LEN_W-1:0] length,
    output logic             busy,
    output logic             done,
    output logic             m_req,
    input  logic             m_grant,
    output logic             m_wr,
    output logic [7:0]       m_address,
    output logic [31:0]      m_dout,
    input  logic [31:0]      m_din
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_sa;
    logic [7:0]       r_da;
    logic [LEN_W-1:0] r_cnt;
    logic [31:0]      r_data;

    // State register; reset drops straight back to IDLE, releasing the bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a write that loses grant falls back to REQ and the
    // word is retried from its read so the data is always fresh
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (length == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (m_grant) begin
                    w_next = S_RD;
                end
            end
            S_RD: begin
                w_next = m_grant ? S_CAP : S_REQ;
            end
            S_CAP: begin
                w_next = S_WR;
            end
            S_WR: begin
                if (!m_grant) begin
                    w_next = S_REQ;
                end else if (r_cnt == LEN_W'(1)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_RD;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Transfer parameters and data buffer; pointers advance only on a
    // completed (granted) write, so a retried word keeps its addresses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sa   <= '0;
            r_da   <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa  <= src_addr;
                        r_da  <= dst_addr;
                        r_cnt <= length;
                    end
                end
                S_CAP: begin
                    r_data <= m_din;
                end
                S_WR: begin
                    if (m_grant) begin
                        r_sa  <= r_sa + 8'd1;
                        r_da  <= r_da + 8'd1;
                        r_cnt <= r_cnt - LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus and status outputs decoded from state; bus lines stay zero unless
    // granted so m_wr can never be seen without grant
    always_comb begin
        busy      = (r_state != S_IDLE);
        done      = (r_state == S_DONE);
        m_req     = 1'b0;
        m_wr      = 1'b0;
        m_address = '0;
        m_dout    = '0;
        case (r_state)
            S_REQ, S_CAP: begin
                m_req = 1'b1;
            end
            S_RD: begin
                m_req = 1'b1;
                if (m_grant) begin
                    m_address = r_sa;
                end
            end
            S_WR: begin
                m_req = 1'b1;
                if (m_grant) begin
                    m_wr      = 1'b1;
                    m_address = r_da;
                    m_dout    = r_data;
                end
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire
